// File: rtl/softplus_result_fifo.sv
// Result collector for the 2-cycle softplus pipe: issues producer samples into the pipe and
// buffers every result in a first-word-fall-through FIFO, with credits covering in-flight work.
module softplus_result_fifo #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       src_valid,
  input  logic [DATA_W-1:0]          src_data,
  output logic                       src_ready,
  output logic                       act_valid,
  output logic [DATA_W-1:0]          act_data,
  input  logic                       res_valid,
  input  logic [DATA_W-1:0]          res_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  if ((DEPTH < PIPE_LAT) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least PIPE_LAT");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_count;
  logic [LW-1:0]     r_inflight;
  logic              r_overflow;

  logic [LW:0]       w_credit_sum;
  logic              w_issue;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_underflow;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high at the
  // clock edge; src_ready depends only on registered state, never on src_valid or out_ready.
  assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_count};
  assign src_ready    = w_credit_sum < (LW+1)'(DEPTH);
  assign w_issue      = src_valid & src_ready;
  assign act_valid    = w_issue;
  assign act_data     = src_data;

  assign w_full       = (r_count == LW'(DEPTH));
  assign out_valid    = (r_count != '0);
  assign w_pop        = out_valid & out_ready;
  assign w_push       = res_valid & (~w_full | w_pop);
  assign w_drop       = res_valid & w_full & ~w_pop;
  assign w_underflow  = res_valid & (r_inflight == '0);

  // Data is zero when the FIFO is empty so the head never shows stale entries.
  assign out_data     = out_valid ? r_mem[r_rd_ptr] : '0;
  assign overflow     = r_overflow;
  assign level        = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= res_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      // Deliberately not saturating: a wrapped counter is paired with the sticky error.
      if (w_issue && !res_valid) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (res_valid && !w_issue) begin
        r_inflight <= r_inflight - 1'b1;
      end
      if (w_drop || w_underflow) begin
        r_overflow <= 1'b1;
      end
    end
  end
endmodule
